// File: rtl/v_init_mb_pkg.sv
// v_init_mb shared types: initialiser FSM states and the
// request bundle for the default context geometry.
package v_init_mb_pkg;

  localparam int unsigned CONTEXT_N     = 128;
  localparam int unsigned CONTEXT_AW    = $clog2(CONTEXT_N);
  localparam int unsigned CONTEXT_W     = 32;
  localparam int unsigned CONTEXT_BANKS = 2;

  typedef enum logic [1:0] {
    SWEEP_ALL,
    IDLE,
    SWEEP_RANGE,
    DONE
  } init_state_t;

  typedef struct packed {
    logic [CONTEXT_AW-1:0]    lo;
    logic [CONTEXT_AW-1:0]    hi;
    logic [CONTEXT_BANKS-1:0] mask;
    logic [CONTEXT_W-1:0]     data;
  } init_req_t;

endpackage

// File: rtl/v_init_mb_if.sv
// v_init_mb_if: range re-init request handshake
// plus the completion pulse.
interface v_init_mb_if
  import v_init_mb_pkg::*;
#(
  parameter int unsigned W       = 32,
  parameter int unsigned N       = 128,
  parameter int unsigned BANKS_N = 2
);
  localparam int unsigned AW = $clog2(N);

  logic               i_req_vld;
  logic               o_req_rdy;
  logic [AW-1:0]      i_req_lo;
  logic [AW-1:0]      i_req_hi;
  logic [BANKS_N-1:0] i_req_mask;
  logic [W-1:0]       i_req_data;
  logic               o_done_vld;
  logic               o_done_err;

  modport master (
    output i_req_vld,
    output i_req_lo,
    output i_req_hi,
    output i_req_mask,
    output i_req_data,
    input  o_req_rdy,
    input  o_done_vld,
    input  o_done_err
  );

  modport slave (
    input  i_req_vld,
    input  i_req_lo,
    input  i_req_hi,
    input  i_req_mask,
    input  i_req_data,
    output o_req_rdy,
    output o_done_vld,
    output o_done_err
  );

endinterface

// File: rtl/v_init_mb_ptr.sv
// v_init_mb_ptr: wrapping address counter with load,
// remaining-count and last-write flag; N need not be 2^k.
module v_init_mb_ptr #(
  parameter  int unsigned N  = 128,
  localparam int unsigned AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [AW-1:0] lo_i,
  input  logic [AW:0]   cnt_i,
  input  logic          step_i,
  output logic [AW-1:0] addr_o,
  output logic          last_o
);

  localparam logic [AW-1:0] TOP = AW'(N - 1);

  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   rem_q, rem_d;

  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    unique case (1'b1)
      load_i: begin
        addr_d = lo_i;
        rem_d  = cnt_i;
      end
      step_i: begin
        addr_d = (addr_q == TOP) ? '0 : addr_q + AW'(1);
        rem_d  = rem_q - (AW+1)'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (rem_q == (AW+1)'(1));

endmodule

// File: rtl/v_init_mb.sv
// v_init_mb: owns the context SRAM write ports; sweeps all banks
// after reset, then serves ranged re-init and functional writes.
module v_init_mb
  import v_init_mb_pkg::*;
#(
  parameter  int unsigned    W          = 32,
  parameter  int unsigned    N          = 128,
  parameter  int unsigned    BANKS_N    = 2,
  parameter  logic [W-1:0]   INIT_VALUE = '0,
  localparam int unsigned    AW         = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  v_init_mb_if.slave            req,
  output logic                  o_busy_r,
  input  logic [BANKS_N-1:0]    i_fn_wen,
  input  logic [BANKS_N*AW-1:0] i_fn_waddr,
  input  logic [BANKS_N*W-1:0]  i_fn_wdata,
  input  logic                  i_fn_drop_clr,
  output logic                  o_fn_drop_r,
  output logic [BANKS_N-1:0]    o_wen,
  output logic [BANKS_N*AW-1:0] o_waddr,
  output logic [BANKS_N*W-1:0]  o_wdata
);

  localparam logic [AW:0] N_W = (AW+1)'(N);

  init_state_t        state_q, state_d;
  logic               busy_q, busy_d;
  logic               rdy_q, rdy_d;
  logic               dvld_q, dvld_d;
  logic               derr_q, derr_d;
  logic               drop_q, drop_d;
  logic [BANKS_N-1:0] wen_q, wen_d;
  logic [W-1:0]       wdata_q, wdata_d;

  logic          ptr_load, ptr_step, ptr_last;
  logic [AW-1:0] ptr_lo, ptr_addr;
  logic [AW:0]   ptr_cnt;

  logic [AW:0] lo_x, hi_x, span, req_cnt;
  logic        req_bad, accept;

  // span is (hi - lo) mod N, one bit wider so N = 2^AW fits
  assign lo_x    = {1'b0, req.i_req_lo};
  assign hi_x    = {1'b0, req.i_req_hi};
  assign span    = (hi_x >= lo_x) ? hi_x - lo_x
                                  : hi_x + N_W - lo_x;
  assign req_cnt = span + (AW+1)'(1);
  assign req_bad = (lo_x >= N_W) || (hi_x >= N_W);
  assign accept  = req.i_req_vld && rdy_q;

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    wen_d    = wen_q;
    wdata_d  = wdata_q;
    dvld_d   = 1'b0;
    derr_d   = 1'b0;
    ptr_load = 1'b0;
    ptr_step = 1'b0;
    ptr_lo   = '0;
    ptr_cnt  = N_W;
    unique case (state_q)
      SWEEP_ALL: begin
        if (~|wen_q) begin
          ptr_load = 1'b1;
          wen_d    = '1;
          wdata_d  = INIT_VALUE;
        end else if (ptr_last) begin
          wen_d   = '0;
          busy_d  = 1'b0;
          dvld_d  = 1'b1;
          state_d = DONE;
        end else begin
          ptr_step = 1'b1;
        end
      end
      SWEEP_RANGE: begin
        if (ptr_last) begin
          wen_d   = '0;
          busy_d  = 1'b0;
          dvld_d  = 1'b1;
          state_d = DONE;
        end else begin
          ptr_step = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      IDLE: begin
        if (accept) begin
          if (req_bad) begin
            dvld_d  = 1'b1;
            derr_d  = 1'b1;
            state_d = DONE;
          end else if (~|req.i_req_mask) begin
            dvld_d  = 1'b1;
            state_d = DONE;
          end else begin
            ptr_load = 1'b1;
            ptr_lo   = req.i_req_lo;
            ptr_cnt  = req_cnt;
            wen_d    = req.i_req_mask;
            wdata_d  = req.i_req_data;
            busy_d   = 1'b1;
            state_d  = SWEEP_RANGE;
          end
        end
      end
    endcase
  end

  assign rdy_d = (state_d == IDLE);

  // a new drop outranks a same-cycle clear
  always_comb begin
    drop_d = drop_q;
    if (busy_q && |i_fn_wen)
      drop_d = 1'b1;
    else if (i_fn_drop_clr)
      drop_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= SWEEP_ALL;
      busy_q  <= 1'b1;
      rdy_q   <= 1'b0;
      dvld_q  <= 1'b0;
      derr_q  <= 1'b0;
      drop_q  <= 1'b0;
      wen_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
      dvld_q  <= dvld_d;
      derr_q  <= derr_d;
      drop_q  <= drop_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
    end
  end

  v_init_mb_ptr #(.N(N)) u_ptr (
    .clk    (clk),
    .rst    (rst),
    .load_i (ptr_load),
    .lo_i   (ptr_lo),
    .cnt_i  (ptr_cnt),
    .step_i (ptr_step),
    .addr_o (ptr_addr),
    .last_o (ptr_last)
  );

  assign o_busy_r       = busy_q;
  assign o_fn_drop_r    = drop_q;
  assign req.o_req_rdy  = rdy_q;
  assign req.o_done_vld = dvld_q;
  assign req.o_done_err = derr_q;

  assign o_wen   = busy_q ? wen_q : i_fn_wen;
  assign o_waddr = busy_q ? {BANKS_N{ptr_addr}} : i_fn_waddr;
  assign o_wdata = busy_q ? {BANKS_N{wdata_q}} : i_fn_wdata;

endmodule

// File: tb/tb_v_init_mb.sv
// tb_v_init_mb: directed vectors for an N=8 and an N=12 build
// sharing clock and reset.
module tb_v_init_mb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  v_init_mb_if #(.W(8), .N(8),  .BANKS_N(2)) if0 ();
  v_init_mb_if #(.W(8), .N(12), .BANKS_N(2)) if1 ();

  logic [1:0] vld;
  logic [3:0] lo, hi;
  logic [1:0] mask;
  logic [7:0] data;

  assign if0.i_req_vld  = vld[0];
  assign if0.i_req_lo   = lo[2:0];
  assign if0.i_req_hi   = hi[2:0];
  assign if0.i_req_mask = mask;
  assign if0.i_req_data = data;
  assign if1.i_req_vld  = vld[1];
  assign if1.i_req_lo   = lo;
  assign if1.i_req_hi   = hi;
  assign if1.i_req_mask = mask;
  assign if1.i_req_data = data;

  logic        busy0, busy1, drop0, drop1, clr0;
  logic [1:0]  fwen0, wen0, wen1;
  logic [5:0]  fwa0, wa0;
  logic [7:0]  wa1;
  logic [15:0] fwd0, wd0, wd1;

  v_init_mb #(.W(8), .N(8), .BANKS_N(2), .INIT_VALUE(8'hA5)) u0 (
    .clk           (clk),
    .rst           (rst),
    .req           (if0),
    .o_busy_r      (busy0),
    .i_fn_wen      (fwen0),
    .i_fn_waddr    (fwa0),
    .i_fn_wdata    (fwd0),
    .i_fn_drop_clr (clr0),
    .o_fn_drop_r   (drop0),
    .o_wen         (wen0),
    .o_waddr       (wa0),
    .o_wdata       (wd0)
  );

  v_init_mb #(.W(8), .N(12), .BANKS_N(2), .INIT_VALUE(8'hA5)) u1 (
    .clk           (clk),
    .rst           (rst),
    .req           (if1),
    .o_busy_r      (busy1),
    .i_fn_wen      (2'b00),
    .i_fn_waddr    (8'h00),
    .i_fn_wdata    (16'h0000),
    .i_fn_drop_clr (1'b0),
    .o_fn_drop_r   (drop1),
    .o_wen         (wen1),
    .o_waddr       (wa1),
    .o_wdata       (wd1)
  );

  bit         sel;
  logic [1:0] m_wen;
  int         m_a0, m_a1;
  logic [7:0] m_d0, m_d1;
  logic       m_busy, m_done, m_err, m_rdy;

  assign m_wen  = sel ? wen1 : wen0;
  assign m_a0   = sel ? int'(wa1[3:0]) : int'(wa0[2:0]);
  assign m_a1   = sel ? int'(wa1[7:4]) : int'(wa0[5:3]);
  assign m_d0   = sel ? wd1[7:0] : wd0[7:0];
  assign m_d1   = sel ? wd1[15:8] : wd0[15:8];
  assign m_busy = sel ? busy1 : busy0;
  assign m_done = sel ? if1.o_done_vld : if0.o_done_vld;
  assign m_err  = sel ? if1.o_done_err : if0.o_done_err;
  assign m_rdy  = sel ? if1.o_req_rdy : if0.o_req_rdy;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input bit s, input int l, input int h,
                           input logic [1:0] mk, input logic [7:0] d,
                           output bit ok);
    int n;
    n   = 0;
    sel = s;
    #1;
    while (!m_rdy && n < 60) begin
      tick();
      n++;
    end
    ok = m_rdy;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL rdy_timeout: got 0 expected 1");
      return;
    end
    lo     = 4'(l);
    hi     = 4'(h);
    mask   = mk;
    data   = d;
    vld[s] = 1'b1;
    tick();
    vld = '0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!m_done && n < 40) begin
      tick();
      n++;
    end
    chk("wait_done", m_done, 1);
  endtask

  // rst has just been raised; the next edge is E0
  task automatic chk_sweep(input int n);
    tick();
    for (int k = 0; k < n; k++) begin
      chk($sformatf("sweep_wen[%0d]", k), m_wen, 2'b11);
      chk($sformatf("sweep_a0[%0d]", k), m_a0, k);
      chk($sformatf("sweep_a1[%0d]", k), m_a1, k);
      chk($sformatf("sweep_d0[%0d]", k), m_d0, 8'hA5);
      chk($sformatf("sweep_busy[%0d]", k), m_busy, 1);
      tick();
    end
    chk("sweep_done", m_done, 1);
    chk("sweep_err", m_err, 0);
    chk("sweep_end_busy", m_busy, 0);
    chk("sweep_end_wen", m_wen, 0);
    chk("sweep_done_rdy", m_rdy, 0);
    tick();
    chk("sweep_done_pulse", m_done, 0);
    chk("sweep_rdy", m_rdy, 1);
  endtask

  typedef struct {
    bit         s;
    int         lo;
    int         hi;
    logic [1:0] mask;
    logic [7:0] data;
    logic       err;
    int         c;
  } vec_t;

  vec_t tv[12];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int ea;
    int nn;

    tv[0]  = '{0, 2, 4, 2'b01, 8'h3C, 1'b0, 3};
    tv[1]  = '{0, 6, 1, 2'b11, 8'h11, 1'b0, 4};
    tv[2]  = '{0, 3, 3, 2'b10, 8'h5A, 1'b0, 1};
    tv[3]  = '{0, 0, 7, 2'b11, 8'h77, 1'b0, 8};
    tv[4]  = '{0, 5, 4, 2'b01, 8'h99, 1'b0, 8};
    tv[5]  = '{0, 1, 2, 2'b00, 8'hFF, 1'b0, 0};
    tv[6]  = '{1, 10, 1, 2'b11, 8'hC3, 1'b0, 4};
    tv[7]  = '{1, 0, 13, 2'b11, 8'hEE, 1'b1, 0};
    tv[8]  = '{1, 12, 1, 2'b01, 8'hEE, 1'b1, 0};
    tv[9]  = '{1, 0, 11, 2'b10, 8'h42, 1'b0, 12};
    tv[10] = '{1, 11, 11, 2'b01, 8'h0F, 1'b0, 1};
    tv[11] = '{1, 4, 3, 2'b00, 8'h24, 1'b0, 0};

    rst   = 1'b0;
    vld   = '0;
    lo    = '0;
    hi    = '0;
    mask  = '0;
    data  = '0;
    fwen0 = '0;
    fwa0  = '0;
    fwd0  = '0;
    clr0  = 1'b0;
    sel   = 0;
    repeat (3) tick();

    chk("rst_busy", m_busy, 1);
    chk("rst_rdy", m_rdy, 0);
    chk("rst_done", m_done, 0);
    chk("rst_err", m_err, 0);
    chk("rst_wen", m_wen, 0);
    chk("rst_drop", drop0, 0);

    rst = 1'b1;
    chk_sweep(8);

    foreach (tv[i]) begin
      start_req(tv[i].s, tv[i].lo, tv[i].hi, tv[i].mask, tv[i].data, ok);
      if (ok) begin
        nn = tv[i].s ? 12 : 8;
        for (int c = 0; c < tv[i].c; c++) begin
          ea = (tv[i].lo + c) % nn;
          chk($sformatf("v%0d_wen[%0d]", i, c), m_wen, tv[i].mask);
          chk($sformatf("v%0d_a0[%0d]", i, c), m_a0, ea);
          chk($sformatf("v%0d_a1[%0d]", i, c), m_a1, ea);
          chk($sformatf("v%0d_d0[%0d]", i, c), m_d0, tv[i].data);
          chk($sformatf("v%0d_d1[%0d]", i, c), m_d1, tv[i].data);
          chk($sformatf("v%0d_busy[%0d]", i, c), m_busy, 1);
          tick();
        end
        chk($sformatf("v%0d_done", i), m_done, 1);
        chk($sformatf("v%0d_err", i), m_err, tv[i].err);
        chk($sformatf("v%0d_end_wen", i), m_wen, 0);
        chk($sformatf("v%0d_end_busy", i), m_busy, 0);
        chk($sformatf("v%0d_done_rdy", i), m_rdy, 0);
        tick();
        chk($sformatf("v%0d_pulse", i), m_done, 0);
      end
    end

    // functional write while busy is dropped, then passes once idle
    start_req(0, 0, 7, 2'b11, 8'h77, ok);
    tick();
    fwen0 = 2'b01;
    fwa0  = {3'd0, 3'd5};
    fwd0  = 16'h00EE;
    #1;
    chk("drop_wen", m_wen, 2'b11);
    chk("drop_a0", m_a0, 1);
    chk("drop_d0", m_d0, 8'h77);
    tick();
    fwen0 = '0;
    chk("drop_set", drop0, 1);
    wait_done();
    tick();
    fwen0 = 2'b01;
    #1;
    chk("pass_wen", m_wen, 2'b01);
    chk("pass_a0", m_a0, 5);
    chk("pass_d0", m_d0, 8'hEE);
    chk("drop_sticky", drop0, 1);
    fwen0 = '0;
    clr0  = 1'b1;
    tick();
    clr0 = 1'b0;
    chk("drop_clr", drop0, 0);
    start_req(0, 0, 3, 2'b01, 8'h22, ok);
    fwen0 = 2'b10;
    clr0  = 1'b1;
    tick();
    fwen0 = '0;
    clr0  = 1'b0;
    chk("drop_set_wins", drop0, 1);
    wait_done();
    tick();

    // reset mid-sweep: no done, full sweep replays
    start_req(0, 0, 7, 2'b11, 8'h77, ok);
    tick();
    chk("abort_a0", m_a0, 1);
    rst = 1'b0;
    tick();
    chk("abort_done0", m_done, 0);
    chk("abort_busy", m_busy, 1);
    chk("abort_wen", m_wen, 0);
    chk("abort_drop", drop0, 0);
    tick();
    chk("abort_done1", m_done, 0);
    rst = 1'b1;
    chk_sweep(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
